// File: rtl/abr_masked_share_pipe.sv
// abr_masked_share_pipe: valid-tagged delay line for Boolean-masked words with runtime depth and optional share refresh
module abr_masked_share_pipe #(
  parameter int WIDTH         = 46,
  parameter int SHARES        = 2,
  parameter int MAX_DEPTH     = 8,
  parameter int DEFAULT_DEPTH = 5,
  parameter int REFRESH       = 0,
  parameter int DW            = $clog2(MAX_DEPTH + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                zeroize,
  input  logic                                en,
  input  logic                                in_valid,
  input  logic [WIDTH*SHARES-1:0]             in_shares,
  input  logic [WIDTH*(SHARES-1)*MAX_DEPTH-1:0] rnd,
  input  logic                                cfg_we,
  input  logic [DW-1:0]                       cfg_depth,
  output logic                                out_valid,
  output logic [WIDTH*SHARES-1:0]             out_shares,
  output logic                                busy,
  output logic                                cfg_err,
  output logic [DW-1:0]                       cur_depth
);
  localparam int SW = WIDTH * SHARES;
  localparam int RW = WIDTH * (SHARES - 1);
  localparam int AW = MAX_DEPTH > 1 ? $clog2(MAX_DEPTH) : 1;
  logic [SW-1:0]        stage_q [MAX_DEPTH];
  logic [SW-1:0]        stage_d [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] vld_q, vld_d;
  logic [DW-1:0]        cnt_q, cnt_d, depth_q, depth_d;
  logic                 err_q, acc;
  logic [AW-1:0]        tap;
  // Each r_s is XORed into share s and also into the last share, so the per-bit XOR is unchanged.
  function automatic logic [SW-1:0] refresh_mask(input logic [RW-1:0] r);
    logic [SW-1:0] m;
    logic          x;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      x = 1'b0;
      for (int s = 0; s < SHARES - 1; s++) begin
        m[i*SHARES+s] = r[i*(SHARES-1)+s];
        x ^= r[i*(SHARES-1)+s];
      end
      m[i*SHARES+SHARES-1] = x;
    end
    return m;
  endfunction
  for (genvar k = 0; k < MAX_DEPTH; k++) begin : g_st
    logic [SW-1:0] src;
    logic          sv;
    if (k == 0) begin : g_head
      assign src = in_valid ? in_shares : '0;
      assign sv  = in_valid;
    end else begin : g_tail
      assign src = stage_q[k-1];
      assign sv  = vld_q[k-1];
    end
    assign stage_d[k] = (REFRESH != 0 && sv) ? src ^ refresh_mask(rnd[k*RW +: RW]) : src;
    assign vld_d[k]   = sv;
  end
  assign cnt_d   = cnt_q + DW'(in_valid) - DW'(vld_q[MAX_DEPTH-1]);
  assign acc     = zeroize || (cnt_q == '0 && (!in_valid || !en));
  assign depth_d = cfg_depth == '0 ? DW'(1) : cfg_depth > DW'(MAX_DEPTH) ? DW'(MAX_DEPTH) : cfg_depth;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '{default: '0};
      vld_q   <= '0;
      cnt_q   <= '0;
      depth_q <= DW'(DEFAULT_DEPTH);
      err_q   <= 1'b0;
    end else begin
      if (cfg_we && acc) depth_q <= depth_d;
      err_q <= cfg_we && !acc;
      if (zeroize) begin
        stage_q <= '{default: '0};
        vld_q   <= '0;
        cnt_q   <= '0;
      end else if (en) begin
        stage_q <= stage_d;
        vld_q   <= vld_d;
        cnt_q   <= cnt_d;
      end
    end
  end
  assign tap        = AW'(depth_q - DW'(1));
  assign out_valid  = vld_q[tap];
  assign out_shares = stage_q[tap];
  assign busy       = cnt_q != '0;
  assign cfg_err    = err_q;
  assign cur_depth  = depth_q;
endmodule
